// File: rtl/nv_ram_rws_param.sv
// rtl/nv_ram_rws_param.sv - parametrised 1W/1R register-file RAM with post-reset zero fill
// Write-first or read-first collision handling, optional output flop, read-valid strobe.
module nv_ram_rws_param #(
  parameter int DEPTH      = 256,
  parameter int AW         = 8,
  parameter int DW         = 4,
  parameter int BYPASS     = 1,
  parameter int OUT_REG    = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra,
  input  logic          re,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  input  logic [AW-1:0] wa,
  input  logic          we,
  input  logic [DW-1:0] di,
  output logic          init_done,
  input  logic [31:0]   pwrbus_ram_pd
);

  typedef enum logic [1:0] {CLEAR, READY_PEND, READY} state_t;

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] clr_cnt, clr_cnt_nxt;
  logic [DW-1:0] mem [0:DEPTH-1];
  logic [DW-1:0] rd_q, rd_data;
  logic          rd_vld;
  logic          ready, rd_acc, wr_acc;
  logic          unused_pwrbus;

  assign unused_pwrbus = ^pwrbus_ram_pd;
  assign ready         = (state == READY);
  assign init_done     = ready;
  assign rd_acc        = ready & re;
  assign wr_acc        = ready & we & ({1'b0, wa} < DEPTH_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= (INIT_CLEAR != 0) ? CLEAR : READY_PEND;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      CLEAR: begin
        clr_cnt_nxt = clr_cnt + AW'(1);
        if (clr_cnt == LAST) begin
          state_nxt   = READY;
          clr_cnt_nxt = '0;
        end
      end
      READY_PEND: state_nxt = READY;
      default: ;
    endcase
  end

  // clr_cnt never exceeds DEPTH-1 in CLEAR, so the fill index is always in range
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_acc) begin
      mem[wa] <= di;
    end
  end

  always_comb begin
    rd_data = mem[ra];
    if ({1'b0, ra} >= DEPTH_W) begin
      rd_data = '0;
    end else if ((BYPASS != 0) && wr_acc && (wa == ra)) begin
      rd_data = di;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q   <= '0;
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= rd_acc;
      if (rd_acc) begin
        rd_q <= rd_data;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DW-1:0] dout_q;
      logic          vld_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_q <= '0;
          vld_q  <= 1'b0;
        end else begin
          dout_q <= rd_q;
          vld_q  <= rd_vld;
        end
      end
      assign dout     = dout_q;
      assign dout_vld = vld_q;
    end else begin : g_no_out_reg
      assign dout     = rd_q;
      assign dout_vld = rd_vld;
    end
  endgenerate

endmodule

// File: tb/tb_nv_ram_rws_param.sv
// tb/tb_nv_ram_rws_param.sv - bench for nv_ram_rws_param
// dut_a: defaults (256x4, write-first, L=1); dut_b: 200x16, read-first, L=2.
module tb_nv_ram_rws_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  ra, wa;
  logic        re, we;
  logic [15:0] di;
  logic [31:0] pwr;
  logic [3:0]  dout_a;
  logic        vld_a, init_a;
  logic [15:0] dout_b;
  logic        vld_b, init_b;

  nv_ram_rws_param dut_a (
    .clk(clk), .rst(rst), .ra(ra), .re(re), .dout(dout_a), .dout_vld(vld_a),
    .wa(wa), .we(we), .di(di[3:0]), .init_done(init_a), .pwrbus_ram_pd(pwr)
  );

  nv_ram_rws_param #(
    .DEPTH(200), .AW(8), .DW(16), .BYPASS(0), .OUT_REG(1), .INIT_CLEAR(1)
  ) dut_b (
    .clk(clk), .rst(rst), .ra(ra), .re(re), .dout(dout_b), .dout_vld(vld_b),
    .wa(wa), .we(we), .di(di), .init_done(init_b), .pwrbus_ram_pd(pwr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: memory images, edge count since reset release, expected outputs.
  int          edges;
  logic [3:0]  m_a [256];
  logic [15:0] m_b [200];
  logic [3:0]  e_a;
  logic        ev_a;
  logic [15:0] e_b, stg_b;
  logic        ev_b, stgv_b;

  task automatic model_reset();
    edges = 0;
    e_a = '0; ev_a = 1'b0;
    e_b = '0; ev_b = 1'b0; stg_b = '0; stgv_b = 1'b0;
    foreach (m_a[i]) m_a[i] = '0;
    foreach (m_b[i]) m_b[i] = '0;
  endtask

  task automatic idle_inputs();
    re = 1'b0; we = 1'b0; ra = '0; wa = '0; di = '0;
  endtask

  // One clock edge: update the model from the inputs present at the edge, then settle.
  task automatic step();
    logic [3:0]  va;
    logic [15:0] vb;
    logic        acc_a, acc_b;
    @(posedge clk);
    if (!rst) begin
      acc_a = (edges >= 256) && re;
      acc_b = (edges >= 200) && re;
      va = (we && wa == ra) ? di[3:0] : m_a[ra];
      vb = (ra >= 8'd200) ? 16'h0 : m_b[ra];
      e_b = stg_b; ev_b = stgv_b;
      stgv_b = acc_b;
      if (acc_b) stg_b = vb;
      ev_a = acc_a;
      if (acc_a) e_a = va;
      if (edges >= 256 && we) m_a[wa] = di[3:0];
      if (edges >= 200 && we && wa < 8'd200) m_b[wa] = di;
      edges++;
    end
    #1;
  endtask

  task automatic hold_reset();
    rst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_ready();
    idle_inputs();
    while (edges < 256) step();
  endtask

  task automatic rand_inputs();
    re = 1'($urandom_range(0, 1));
    we = 1'($urandom_range(0, 1));
    ra = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(190, 215)) : 8'($urandom_range(0, 15));
    wa = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(190, 215)) : 8'($urandom_range(0, 15));
    di = 16'($urandom);
  endtask

  task automatic test_reset();
    int first_a, first_b;
    rst = 1'b1;
    idle_inputs();
    model_reset();
    #2;
    n_tests++;
    if (dout_a !== 4'h0 || vld_a !== 1'b0 || init_a !== 1'b0 ||
        dout_b !== 16'h0 || vld_b !== 1'b0 || init_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vals: a=%h/%b/%b b=%h/%b/%b required all zero",
               dout_a, vld_a, init_a, dout_b, vld_b, init_b);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    first_a = 0; first_b = 0;
    for (int k = 0; k < 300; k++) begin
      ra = 8'($urandom); wa = 8'($urandom); di = 16'($urandom);
      re = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
      step();
      if (init_a && first_a == 0) first_a = edges;
      if (init_b && first_b == 0) first_b = edges;
      n_tests++;
      if (dout_a !== e_a || vld_a !== ev_a || dout_b !== e_b || vld_b !== ev_b) begin
        n_fail++;
        $display("FAIL clear_traffic edge %0d: a=%h/%b b=%h/%b required a=%h/%b b=%h/%b",
                 edges, dout_a, vld_a, dout_b, vld_b, e_a, ev_a, e_b, ev_b);
      end
    end
    n_tests++;
    if (first_a != 256) begin
      n_fail++;
      $display("FAIL init_edges_a: got %0d required 256", first_a);
    end
    n_tests++;
    if (first_b != 200) begin
      n_fail++;
      $display("FAIL init_edges_b: got %0d required 200", first_b);
    end
  endtask

  task automatic test_read_zero();
    logic [7:0] addrs [3];
    addrs[0] = 8'd0; addrs[1] = 8'd127; addrs[2] = 8'd255;
    hold_reset();
    wait_ready();
    for (int i = 0; i < 3; i++) begin
      re = 1'b1; ra = addrs[i];
      step();
      n_tests++;
      if (dout_a !== 4'h0 || vld_a !== 1'b1) begin
        n_fail++;
        $display("FAIL read_zero addr %0d: dout=%h vld=%b required 0/1", addrs[i], dout_a, vld_a);
      end
    end
    re = 1'b0;
    step();
    n_tests++;
    if (vld_a !== 1'b0 || vld_b !== 1'b1 || dout_b !== 16'h0) begin
      n_fail++;
      $display("FAIL read_zero_tail: vld_a=%b vld_b=%b dout_b=%h required 0/1/0", vld_a, vld_b, dout_b);
    end
  endtask

  task automatic test_write_read();
    we = 1'b1; wa = 8'h10; di = 16'h000A;
    step();
    we = 1'b0; re = 1'b1; ra = 8'h10;
    step();
    n_tests++;
    if (dout_a !== 4'hA || vld_a !== 1'b1 || vld_b !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_rd_1: dout_a=%h vld_a=%b vld_b=%b required A/1/0", dout_a, vld_a, vld_b);
    end
    re = 1'b0;
    step();
    n_tests++;
    if (dout_a !== 4'hA || vld_a !== 1'b0 || dout_b !== 16'h000A || vld_b !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_rd_2: a=%h/%b b=%h/%b required A/0 000a/1", dout_a, vld_a, dout_b, vld_b);
    end
    step();
    n_tests++;
    if (dout_a !== 4'hA || vld_a !== 1'b0 || dout_b !== 16'h000A || vld_b !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_rd_hold: a=%h/%b b=%h/%b required A/0 000a/0", dout_a, vld_a, dout_b, vld_b);
    end
  endtask

  task automatic test_collision();
    we = 1'b1; wa = 8'd5; di = 16'h0003;
    step();
    we = 1'b1; wa = 8'd5; di = 16'h000C; re = 1'b1; ra = 8'd5;
    step();
    n_tests++;
    if (dout_a !== 4'hC || vld_a !== 1'b1) begin
      n_fail++;
      $display("FAIL collide_a: dout=%h vld=%b required C/1", dout_a, vld_a);
    end
    we = 1'b0;
    step();
    n_tests++;
    if (dout_b !== 16'h0003 || vld_b !== 1'b1 || dout_a !== 4'hC) begin
      n_fail++;
      $display("FAIL collide_b: dout_b=%h vld_b=%b dout_a=%h required 0003/1/C", dout_b, vld_b, dout_a);
    end
    re = 1'b0;
    step();
    n_tests++;
    if (dout_b !== 16'h000C || vld_b !== 1'b1) begin
      n_fail++;
      $display("FAIL after_collide_b: dout=%h vld=%b required 000c/1", dout_b, vld_b);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; wa = 8'(i); di = 16'(i * 16'h0101);
      step();
    end
    we = 1'b0; re = 1'b1;
    for (int i = 0; i < 9; i++) begin
      ra = 8'(i);
      if (i == 8) re = 1'b0;
      step();
      if (i < 8) begin
        n_tests++;
        if (dout_a !== 4'(i) || vld_a !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_a %0d: dout=%h vld=%b required %h/1", i, dout_a, vld_a, 4'(i));
        end
      end
      if (i >= 1) begin
        n_tests++;
        if (dout_b !== 16'((i - 1) * 16'h0101) || vld_b !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_b %0d: dout=%h vld=%b required %h/1", i - 1, dout_b, vld_b,
                   16'((i - 1) * 16'h0101));
        end
      end else begin
        n_tests++;
        if (vld_b !== 1'b0) begin
          n_fail++;
          $display("FAIL stream_b_lat: vld=%b required 0 one edge after first read", vld_b);
        end
      end
    end
    step();
    n_tests++;
    if (vld_b !== 1'b0 || vld_a !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_end: vld_a=%b vld_b=%b required 0/0", vld_a, vld_b);
    end
  endtask

  task automatic test_out_of_range();
    we = 1'b1; wa = 8'd210; di = 16'hFFFF;
    step();
    wa = 8'd199; di = 16'h1234;
    step();
    we = 1'b0; re = 1'b1; ra = 8'd210;
    step();
    n_tests++;
    if (dout_a !== 4'hF || vld_a !== 1'b1) begin
      n_fail++;
      $display("FAIL oob_a_inrange: dout=%h vld=%b required F/1", dout_a, vld_a);
    end
    ra = 8'd199;
    step();
    n_tests++;
    if (dout_b !== 16'h0000 || vld_b !== 1'b1) begin
      n_fail++;
      $display("FAIL oob_b_read210: dout=%h vld=%b required 0000/1", dout_b, vld_b);
    end
    re = 1'b0;
    step();
    n_tests++;
    if (dout_b !== 16'h1234 || vld_b !== 1'b1) begin
      n_fail++;
      $display("FAIL oob_b_read199: dout=%h vld=%b required 1234/1", dout_b, vld_b);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rand_inputs();
      step();
      n_tests++;
      if (dout_a !== e_a || vld_a !== ev_a || dout_b !== e_b || vld_b !== ev_b) begin
        n_fail++;
        $display("FAIL random cyc %0d: a=%h/%b b=%h/%b required a=%h/%b b=%h/%b",
                 k, dout_a, vld_a, dout_b, vld_b, e_a, ev_a, e_b, ev_b);
      end
    end
  endtask

  task automatic test_mid_reset();
    int first_a;
    hold_reset();
    repeat (99) step();
    re = 1'b1; we = 1'b1; ra = 8'd3; wa = 8'd3; di = 16'h5555;
    step();
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (dout_a !== 4'h0 || vld_a !== 1'b0 || init_a !== 1'b0) begin
      n_fail++;
      $display("FAIL midclear_rst: a=%h/%b/%b required 0/0/0", dout_a, vld_a, init_a);
    end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    first_a = 0;
    for (int k = 0; k < 300 && first_a == 0; k++) begin
      rand_inputs();
      step();
      if (init_a) first_a = edges;
      n_tests++;
      if (dout_a !== e_a || vld_a !== ev_a || dout_b !== e_b || vld_b !== ev_b) begin
        n_fail++;
        $display("FAIL reclear cyc %0d: a=%h/%b b=%h/%b required a=%h/%b b=%h/%b",
                 k, dout_a, vld_a, dout_b, vld_b, e_a, ev_a, e_b, ev_b);
      end
    end
    n_tests++;
    if (first_a != 256) begin
      n_fail++;
      $display("FAIL reclear_edges: got %0d required 256", first_a);
    end
    re = 1'b1; we = 1'b0; ra = 8'd7;
    step();
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (dout_a !== 4'h0 || vld_a !== 1'b0 || dout_b !== 16'h0 || vld_b !== 1'b0 || init_b !== 1'b0) begin
      n_fail++;
      $display("FAIL inflight_rst: a=%h/%b b=%h/%b/%b required all zero", dout_a, vld_a, dout_b, vld_b, init_b);
    end
    model_reset();
    idle_inputs();
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    n_tests++;
    if (vld_b !== 1'b0 || dout_b !== 16'h0) begin
      n_fail++;
      $display("FAIL inflight_discard: dout_b=%h vld_b=%b required 0/0", dout_b, vld_b);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    pwr = 32'hDEAD_BEEF;
    test_reset();
    test_read_zero();
    test_write_read();
    test_collision();
    test_stream();
    test_out_of_range();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
